pcie_lcrc32_check: RTL and testbench
====================================

# pcie_lcrc32_check

Receive-side LCRC checker for the data link layer. It accepts received TLP frames as 32-bit beats: a sequence-number beat, the TLP dwords, then the LCRC beat. It recomputes the LCRC on the fly, strips the sequence and LCRC beats, and forwards the TLP dwords to the transaction-layer receive path. For every frame it reports one verdict (good, nullified or bad) and the frame's sequence number to the ACK/NAK logic.

## Interface
- `DATA_W`, default 32: beat width; fixed at 32, other values are illegal.
- `CNT_W`, default 16: width of the statistics counters.
- `clk_i`, in, 1: clock; the block uses this single clock.
- `rst_ni`, in, 1: reset; asynchronous, active-low.
- `s_tvalid_i` / `s_tready_o`, in/out, 1: input beat handshake.
- `s_tdata_i`, in, 32: input beat, byte order already normalized by the deframer.
- `s_tlast_i`, in, 1: marks the LCRC beat.
- `s_nullify_i`, in, 1: EDB-terminated frame; sampled only with `s_tlast_i`.
- `m_tvalid_o` / `m_tready_i`, out/in, 1: output TLP-dword handshake.
- `m_tdata_o`, out, 32: TLP dword.
- `m_tlast_o`, out, 1: marks the last TLP dword.
- `stat_valid_o`, out, 1: one-cycle verdict pulse.
- `stat_good_o`, `stat_null_o`, `stat_bad_o`, out, 1 each: verdict, one-hot while `stat_valid_o` is high.
- `stat_seq_o`, out, 12: sequence number of the judged frame.
- `cnt_clr_i`, in, 1: synchronous clear of all counters.
- `good_cnt_o`, `null_cnt_o`, `bad_cnt_o`, out, `CNT_W` each: saturating frame counters.

## Operation
- **CRC state:** `crc_q` is seeded to `32'hFFFF_FFFF` at the start of each frame. Every accepted non-LCRC beat updates it: `crc_q <= pcie_lcrc32(crc_q, beat)`. The sequence beat is included in full (all 32 bits); the LCRC beat is never included.
- **States:**
  - SEQ: expects the sequence beat. It captures `seq_q = s_tdata_i[11:0]` and moves to FIRST. Bits [31:12] are not checked but are covered by the CRC.
  - FIRST: expects the first TLP dword. It loads the hold register H (`h_valid` set) and moves to BODY.
  - BODY: H is full. A non-last input beat emits H with `m_tlast_o=0` and loads the new beat into H. A last input beat emits H with `m_tlast_o=1`, issues the verdict and returns to SEQ.
- **Verdict:**
  - good: `!s_nullify_i` and `s_tdata_i == ~crc_q`.
  - nullified: `s_nullify_i` and `s_tdata_i == crc_q`.
  - bad: every other case, including nullify with a mismatching LCRC.
  - Data forwarded from a bad or nullified frame is still delivered; the consumer discards it based on the verdict.
- **Short frames:**
  - `s_tlast_i` in SEQ (1-beat frame) → bad, no output beats.
  - `s_tlast_i` in FIRST (seq + LCRC only) → bad, no output beats, no LCRC compare.
- **Counters:** on `stat_valid_o`, the matching counter increments and saturates at all-ones. `cnt_clr_i` wins over a simultaneous increment.
- **Reset mid-frame:** the partial frame is dropped, no verdict is issued, and the block restarts in SEQ.

## Timing
- `s_tready_o` is 1 in SEQ and FIRST, and equals `m_tready_i` in BODY.
- `m_tvalid_o = (state==BODY) & h_valid & s_tvalid_i`. `m_tdata_o = H`. `m_tlast_o = s_tlast_i`.
- Output beats therefore lag input beats by one beat and are combinationally gated by the next input beat.
- `m_tvalid_o` must not depend on `m_tready_i`.
- Verdict and `stat_seq_o` are registered and appear one cycle after the LCRC (or short-frame) beat handshake. `stat_valid_o` is high for exactly one cycle.
- Counters update in the same cycle that `stat_valid_o` is high.
- Back-to-back frames are accepted with no idle cycle: a SEQ beat can follow an LCRC beat immediately.
- Reset values:
  - state = SEQ, `crc_q = 32'hFFFF_FFFF`, `h_valid = 0`, `seq_q = 0`.
  - All `stat_*` outputs 0 and all counters 0.
  - `m_tvalid_o = 0`; `s_tready_o = 1` once reset is released.

## Structure
- Shared package `pcie_dll_pkg` holds:
  - `LCRC_SEED = 32'hFFFF_FFFF`;
  - `SEQ_W = 12`;
  - the state enum `lcrc_chk_state_e {SEQ, FIRST, BODY}`;
  - the verdict enum `lcrc_verdict_e {GOOD, NULLIFIED, BAD}`.
- One sub-module instance: `pcie_lcrc32` (combinational 32-bit step), fed by `crc_q` (or `LCRC_SEED` in SEQ) and `s_tdata_i`.

## Test plan
1. **Good frame:** seq beat 0x0000_0005, dwords 0x11111111/0x22222222/0x33333333, then the model-computed LCRC (~crc). Required: 3 output beats in order, `m_tlast_o` on 0x33333333, `stat_good_o=1`, `stat_seq_o=0x005`, `good_cnt_o` goes 0→1.
2. **Corrupt LCRC:** same frame with bit 0 of the LCRC flipped. Required: `stat_bad_o=1`, `bad_cnt_o=1`, the 3 dwords are still forwarded.
3. **Nullified frame:** `s_nullify_i=1` with LCRC = the un-complemented CRC. Required: `stat_null_o=1`. The same frame with the complemented CRC → `stat_bad_o=1`.
4. **Short frames:** a 1-beat frame and a seq+LCRC frame. Required: a bad verdict for each, zero `m_tvalid_o` cycles, `bad_cnt_o=2`.
5. **Backpressure and throughput:** random `m_tready_i` stalls over 20 back-to-back good frames. Required: no lost or duplicated dwords, `good_cnt_o=20`, `s_tready_o` follows `m_tready_i` in BODY.
6. **Reset and counters:**
   - Assert `rst_ni` low mid-BODY, then send a good frame. Required: no verdict for the aborted frame, the new frame is good with `crc_q` reseeded.
   - Preload a counter to 0xFFFF. Required: it stays 0xFFFF on the next increment.
   - Assert `cnt_clr_i` together with a verdict. Required: the counter reads 0.

Source files
------------

// File: rtl/pcie_dll_pkg.sv
// Shared data-link-layer types and constants for the receive-side LCRC path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package pcie_dll_pkg;

  localparam logic [31:0] LCRC_SEED = 32'hFFFF_FFFF;
  localparam logic [31:0] LCRC_POLY = 32'h04C1_1DB7;
  localparam int          SEQ_W     = 12;

  typedef enum logic [1:0] {
    SEQ,
    FIRST,
    BODY
  } lcrc_chk_state_e;

  typedef enum logic [1:0] {
    GOOD,
    NULLIFIED,
    BAD
  } lcrc_verdict_e;

endpackage

// File: rtl/pcie_lcrc32.sv
// One 32-bit LCRC step: folds a full beat into the running CRC, MSB first.
// Latency: combinational.
// Backpressure: none, pure function of its inputs.
module pcie_lcrc32
  import pcie_dll_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [31:0] data_i,
  output logic [31:0] crc_o
);

  // Bit-serial shift unrolled over the beat, data bit 31 enters first.
  always_comb begin
    logic [31:0] c;
    c = crc_i;
    for (int i = 31; i >= 0; i--) begin
      if (c[31] ^ data_i[i]) begin
        c = {c[30:0], 1'b0} ^ LCRC_POLY;
      end else begin
        c = {c[30:0], 1'b0};
      end
    end
    crc_o = c;
  end

endmodule

// File: rtl/pcie_lcrc32_check.sv
// Strips seq/LCRC beats, forwards TLP dwords, judges each frame good/nullified/bad.
// Latency: output dword lags its input by one beat; verdict one cycle after LCRC beat.
// Backpressure: in BODY s_tready_o mirrors m_tready_i; SEQ/FIRST always ready.
module pcie_lcrc32_check
  import pcie_dll_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              s_tvalid_i,
  output logic              s_tready_o,
  input  logic [DATA_W-1:0] s_tdata_i,
  input  logic              s_tlast_i,
  input  logic              s_nullify_i,
  output logic              m_tvalid_o,
  input  logic              m_tready_i,
  output logic [DATA_W-1:0] m_tdata_o,
  output logic              m_tlast_o,
  output logic              stat_valid_o,
  output logic              stat_good_o,
  output logic              stat_null_o,
  output logic              stat_bad_o,
  output logic [SEQ_W-1:0]  stat_seq_o,
  input  logic              cnt_clr_i,
  output logic [CNT_W-1:0]  good_cnt_o,
  output logic [CNT_W-1:0]  null_cnt_o,
  output logic [CNT_W-1:0]  bad_cnt_o
);

  lcrc_chk_state_e   state_q, state_d;
  lcrc_verdict_e     verdict_d;
  logic              vld_d;
  logic [DATA_W-1:0] crc_q, crc_in, crc_nxt;
  logic [DATA_W-1:0] h_q;
  logic              h_valid_q;
  logic [SEQ_W-1:0]  seq_q, seq_src;
  logic              s_hs;

  assign s_tready_o = (state_q == BODY) ? m_tready_i : 1'b1;
  assign s_hs       = s_tvalid_i & s_tready_o;
  assign m_tvalid_o = (state_q == BODY) & h_valid_q & s_tvalid_i;
  assign m_tdata_o  = h_q;
  assign m_tlast_o  = s_tlast_i;

  // A 1-beat frame has only its own beat to report a sequence number from.
  assign seq_src = (state_q == SEQ) ? s_tdata_i[SEQ_W-1:0] : seq_q;
  assign crc_in  = (state_q == SEQ) ? LCRC_SEED : crc_q;

  pcie_lcrc32 u_lcrc (
    .crc_i  (crc_in),
    .data_i (s_tdata_i),
    .crc_o  (crc_nxt)
  );

  // Frame-position state register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state_q <= SEQ;
    else         state_q <= state_d;
  end

  // Next state and verdict; short frames are always bad without an LCRC compare.
  always_comb begin
    state_d   = state_q;
    vld_d     = 1'b0;
    verdict_d = BAD;
    case (state_q)
      SEQ: begin
        if (s_hs) begin
          if (s_tlast_i) vld_d   = 1'b1;
          else           state_d = FIRST;
        end
      end
      FIRST: begin
        if (s_hs) begin
          if (s_tlast_i) begin
            vld_d   = 1'b1;
            state_d = SEQ;
          end else begin
            state_d = BODY;
          end
        end
      end
      BODY: begin
        if (s_hs && s_tlast_i) begin
          vld_d   = 1'b1;
          state_d = SEQ;
          if (!s_nullify_i && (s_tdata_i == ~crc_q))     verdict_d = GOOD;
          else if (s_nullify_i && (s_tdata_i == crc_q))  verdict_d = NULLIFIED;
          else                                           verdict_d = BAD;
        end
      end
      default: state_d = SEQ;
    endcase
  end

  // Running CRC over seq and TLP beats; reseeded once the LCRC beat is consumed.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)       crc_q <= LCRC_SEED;
    else if (s_hs)     crc_q <= s_tlast_i ? LCRC_SEED : crc_nxt;
  end

  // Hold register delays each dword until the next beat reveals whether it is last.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      h_q       <= '0;
      h_valid_q <= 1'b0;
      seq_q     <= '0;
    end else if (s_hs) begin
      if (state_q == SEQ) seq_q <= s_tdata_i[SEQ_W-1:0];
      if (s_tlast_i) begin
        h_valid_q <= 1'b0;
      end else if (state_q != SEQ) begin
        h_q       <= s_tdata_i;
        h_valid_q <= 1'b1;
      end
    end
  end

  // Registered one-cycle verdict pulse with the judged sequence number.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stat_valid_o <= 1'b0;
      stat_good_o  <= 1'b0;
      stat_null_o  <= 1'b0;
      stat_bad_o   <= 1'b0;
      stat_seq_o   <= '0;
    end else begin
      stat_valid_o <= vld_d;
      stat_good_o  <= vld_d && (verdict_d == GOOD);
      stat_null_o  <= vld_d && (verdict_d == NULLIFIED);
      stat_bad_o   <= vld_d && (verdict_d == BAD);
      if (vld_d) stat_seq_o <= seq_src;
    end
  end

  // Saturating verdict counters, moving together with the verdict pulse; clear wins.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      good_cnt_o <= '0;
      null_cnt_o <= '0;
      bad_cnt_o  <= '0;
    end else if (cnt_clr_i) begin
      good_cnt_o <= '0;
      null_cnt_o <= '0;
      bad_cnt_o  <= '0;
    end else if (vld_d) begin
      if (verdict_d == GOOD && good_cnt_o != '1)      good_cnt_o <= good_cnt_o + 1'b1;
      if (verdict_d == NULLIFIED && null_cnt_o != '1) null_cnt_o <= null_cnt_o + 1'b1;
      if (verdict_d == BAD && bad_cnt_o != '1)        bad_cnt_o  <= bad_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_pcie_lcrc32_check.sv
// Directed + randomized bench for the LCRC checker with a polynomial-division CRC model.
// Latency: n/a.
// Backpressure: random m_tready stalls during the throughput phase.
module tb_pcie_lcrc32_check;

  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             s_tvalid, s_tready, s_tlast, s_nullify;
  logic [31:0]      s_tdata;
  logic             m_tvalid, m_tready, m_tlast;
  logic [31:0]      m_tdata;
  logic             stat_valid, stat_good, stat_null, stat_bad;
  logic [11:0]      stat_seq;
  logic             cnt_clr;
  logic [CNT_W-1:0] good_cnt, null_cnt, bad_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pcie_lcrc32_check #(.DATA_W(32), .CNT_W(CNT_W)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .s_tvalid_i   (s_tvalid),
    .s_tready_o   (s_tready),
    .s_tdata_i    (s_tdata),
    .s_tlast_i    (s_tlast),
    .s_nullify_i  (s_nullify),
    .m_tvalid_o   (m_tvalid),
    .m_tready_i   (m_tready),
    .m_tdata_o    (m_tdata),
    .m_tlast_o    (m_tlast),
    .stat_valid_o (stat_valid),
    .stat_good_o  (stat_good),
    .stat_null_o  (stat_null),
    .stat_bad_o   (stat_bad),
    .stat_seq_o   (stat_seq),
    .cnt_clr_i    (cnt_clr),
    .good_cnt_o   (good_cnt),
    .null_cnt_o   (null_cnt),
    .bad_cnt_o    (bad_cnt)
  );

  // Scoreboard state: expected/observed dwords {last,data}, verdicts {dc,g,n,b,seq}.
  logic [32:0] exp_d[$], obs_d[$];
  logic [15:0] exp_v[$];
  logic [14:0] obs_v[$];
  logic [31:0] fq[$];
  int eg = 0, en = 0, eb = 0;
  int cyc = 0, lcrc_cyc = -10, mv_cycles = 0;
  bit rand_rdy = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // CRC as remainder of ((crc ^ word) * x^32) divided by the generator polynomial.
  function automatic logic [31:0] crc_step(input logic [31:0] crc, input logic [31:0] w);
    logic [63:0] r;
    logic [63:0] g;
    r = {crc ^ w, 32'h0};
    g = {31'h0, 33'h1_04C1_1DB7};
    for (int i = 63; i >= 32; i--) begin
      if (r[i]) r = r ^ (g << (i - 32));
    end
    return r[31:0];
  endfunction

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  // Random output backpressure, changed just after each active edge.
  always @(posedge clk) begin
    #1;
    m_tready = rand_rdy ? ($urandom_range(0, 3) != 0) : 1'b1;
  end

  // Passive monitor sampled mid-cycle.
  always @(negedge clk) begin
    cyc++;
    if (rst_n) begin
      if (stat_valid) begin
        check("stat_latency", 64'(cyc), 64'(lcrc_cyc + 1));
        check("stat_onehot", 64'($countones({stat_good, stat_null, stat_bad})), 64'd1);
        obs_v.push_back({stat_good, stat_null, stat_bad, stat_seq});
      end
      if (s_tvalid && s_tready && s_tlast) lcrc_cyc = cyc;
      if (m_tvalid) begin
        mv_cycles++;
        check("s_rdy_follow", 64'(s_tready), 64'(m_tready));
        if (m_tready) obs_d.push_back({m_tlast, m_tdata});
      end
    end
  end

  task automatic send_beat(input logic [31:0] d, input logic last, input logic nul);
    int  n;
    logic ok;
    s_tvalid  = 1'b1;
    s_tdata   = d;
    s_tlast   = last;
    s_nullify = nul;
    n = 0;
    forever begin
      @(negedge clk);
      ok = s_tready;
      @(posedge clk);
      #1;
      if (ok) break;
      n++;
      if (n > 1000) begin
        tests++;
        fails++;
        $error("FAIL hs_timeout: observed no handshake expected handshake");
        break;
      end
    end
  endtask

  task automatic idle(input int n);
    s_tvalid  = 1'b0;
    s_tlast   = 1'b0;
    s_nullify = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // kind: 0 good, 1 corrupted LCRC, 2 nullified, 3 nullify with complemented CRC.
  task automatic send_frame(input logic [31:0] seqw, input int kind, input bit clr);
    logic [31:0] crc, lcrc;
    logic        nul;
    logic [2:0]  v;
    int          nd;
    nd  = fq.size();
    crc = crc_step(32'hFFFF_FFFF, seqw);
    for (int i = 0; i < nd; i++) begin
      crc = crc_step(crc, fq[i]);
      exp_d.push_back({(i == nd - 1), fq[i]});
    end
    case (kind)
      0:       begin lcrc = ~crc;           nul = 1'b0; v = 3'b100; end
      1:       begin lcrc = ~crc ^ 32'h1;   nul = 1'b0; v = 3'b001; end
      2:       begin lcrc = crc;            nul = 1'b1; v = 3'b010; end
      default: begin lcrc = ~crc;           nul = 1'b1; v = 3'b001; end
    endcase
    exp_v.push_back({1'b0, v, seqw[11:0]});
    send_beat(seqw, 1'b0, 1'b0);
    for (int i = 0; i < nd; i++) send_beat(fq[i], 1'b0, 1'b0);
    if (clr) cnt_clr = 1'b1;
    send_beat(lcrc, 1'b1, nul);
    if (clr) begin
      idle(1);
      cnt_clr = 1'b0;
      eg = 0; en = 0; eb = 0;
    end else begin
      if (v[2]) eg = sat(eg);
      if (v[1]) en = sat(en);
      if (v[0]) eb = sat(eb);
    end
  endtask

  task automatic expect_short_bad(input logic [11:0] seq, input bit dc);
    exp_v.push_back({dc, 3'b001, seq});
    eb = sat(eb);
  endtask

  task automatic drain(input string tag);
    idle(3);
    check({tag, "_ndw"}, 64'(obs_d.size()), 64'(exp_d.size()));
    for (int i = 0; i < exp_d.size(); i++)
      if (i < obs_d.size()) check({tag, "_dw"}, 64'(obs_d[i]), 64'(exp_d[i]));
    check({tag, "_nverd"}, 64'(obs_v.size()), 64'(exp_v.size()));
    for (int i = 0; i < exp_v.size(); i++)
      if (i < obs_v.size()) begin
        if (exp_v[i][15]) check({tag, "_verd"}, 64'(obs_v[i][14:12]), 64'(exp_v[i][14:12]));
        else              check({tag, "_verd"}, 64'(obs_v[i]), 64'(exp_v[i][14:0]));
      end
    exp_d.delete(); obs_d.delete(); exp_v.delete(); obs_v.delete();
  endtask

  task automatic check_cnts(input string tag);
    check({tag, "_good_cnt"}, 64'(good_cnt), 64'(eg));
    check({tag, "_null_cnt"}, 64'(null_cnt), 64'(en));
    check({tag, "_bad_cnt"},  64'(bad_cnt),  64'(eb));
  endtask

  initial begin
    logic [31:0] r;
    int          mv0;
    rst_n = 1'b0; s_tvalid = 1'b0; s_tdata = '0; s_tlast = 1'b0; s_nullify = 1'b0;
    m_tready = 1'b1; cnt_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Reset state.
    @(negedge clk);
    check("rst_s_tready", 64'(s_tready), 64'd1);
    check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
    check("rst_stat_valid", 64'(stat_valid), 64'd0);
    check("rst_stat_flags", 64'({stat_good, stat_null, stat_bad}), 64'd0);
    check("rst_stat_seq", 64'(stat_seq), 64'd0);
    check_cnts("rst");
    @(posedge clk); #1;

    // Good frame with fixed contents.
    fq = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
    send_frame(32'h0000_0005, 0, 1'b0);
    drain("good");
    check_cnts("good");

    // Corrupted LCRC: data still forwarded, verdict bad.
    send_frame(32'h0000_0005, 1, 1'b0);
    drain("corrupt");
    check_cnts("corrupt");

    // Nullified frame, then nullify with a complemented CRC.
    fq = '{32'hDEAD_BEEF, 32'h0123_4567};
    send_frame(32'hABC0_0123, 2, 1'b0);
    send_frame(32'hABC0_0124, 3, 1'b0);
    drain("nullify");
    check_cnts("nullify");

    // Counter clear while idle.
    cnt_clr = 1'b1; idle(1); cnt_clr = 1'b0;
    eg = 0; en = 0; eb = 0;
    check_cnts("clr_idle");

    // Short frames: 1-beat, then seq + LCRC only.
    mv0 = mv_cycles;
    r = $urandom;
    send_beat(r, 1'b1, 1'b0);
    expect_short_bad(r[11:0], 1'b1);
    r = $urandom;
    send_beat(r, 1'b0, 1'b0);
    expect_short_bad(r[11:0], 1'b0);
    send_beat($urandom, 1'b1, 1'b0);
    drain("short");
    check("short_no_mvalid", 64'(mv_cycles), 64'(mv0));
    check_cnts("short");

    // Back-to-back random good frames under random backpressure.
    cnt_clr = 1'b1; idle(1); cnt_clr = 1'b0;
    eg = 0; en = 0; eb = 0;
    rand_rdy = 1;
    for (int f = 0; f < 20; f++) begin
      fq.delete();
      for (int k = 0; k < $urandom_range(1, 6); k++) fq.push_back($urandom);
      send_frame($urandom, 0, 1'b0);
    end
    rand_rdy = 0;
    drain("stream");
    check_cnts("stream");

    // Reset in the middle of BODY, then a fresh good frame.
    send_beat(32'h0000_0077, 1'b0, 1'b0);
    send_beat($urandom, 1'b0, 1'b0);
    send_beat($urandom, 1'b0, 1'b0);
    s_tvalid = 1'b0;
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(3);
    check("midrst_no_verdict", 64'(obs_v.size()), 64'd0);
    check("midrst_m_tvalid", 64'(m_tvalid), 64'd0);
    exp_d.delete(); obs_d.delete(); exp_v.delete(); obs_v.delete();
    eg = 0; en = 0; eb = 0;
    check_cnts("midrst");
    fq = '{$urandom, $urandom};
    send_frame(32'h0000_0ABC, 0, 1'b0);
    drain("after_rst");
    check_cnts("after_rst");

    // Saturation of the bad counter.
    for (int i = 0; i < CMAX; i++) begin
      r = $urandom;
      send_beat(r, 1'b1, 1'b0);
      expect_short_bad(r[11:0], 1'b1);
    end
    idle(2);
    check("sat_reach", 64'(bad_cnt), 64'(CMAX));
    r = $urandom;
    send_beat(r, 1'b1, 1'b0);
    expect_short_bad(r[11:0], 1'b1);
    drain("sat");
    check("sat_hold", 64'(bad_cnt), 64'(CMAX));

    // Clear coinciding with a verdict.
    fq = '{32'hCAFE_F00D};
    send_frame(32'h0000_0100, 0, 1'b1);
    drain("clr_verdict");
    check_cnts("clr_verdict");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
